// File: rtl/tohost_reader.sv
// tohost_reader: captures CSR tohost writes into a small FIFO for the host
// and tracks RUN/PASS/FAIL test status from the written values.
module tohost_reader #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csr_we,
  input  logic [31:0]       csr_wdata,
  output logic              host_valid,
  input  logic              host_ready,
  output logic [31:0]       host_data,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              done,
  output logic              pass,
  output logic [30:0]       fail_code
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_e;

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             ovf_q;
  state_e           state_q;
  logic             done_q;
  logic             pass_q;
  logic [30:0]      fail_code_q;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && host_ready;
  assign push  = csr_we && (!full || pop);
  assign drop  = csr_we && full && !pop;

  // Occupancy: push and pop together leave the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents before reset are hidden by the empty gate.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= csr_wdata;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Status FSM; PASS and FAIL are terminal until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (csr_we && csr_wdata[0]) begin
            done_q <= 1'b1;
            if (csr_wdata == 32'h1) begin
              state_q <= PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q     <= FAIL;
              fail_code_q <= csr_wdata[31:1];
            end
          end
        end
        PASS:    state_q <= PASS;
        FAIL:    state_q <= FAIL;
        default: state_q <= RUN;
      endcase
    end
  end

  assign host_valid = !empty;
  assign host_data  = empty ? 32'h0 : mem_q[rd_ptr_q];
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_code  = fail_code_q;

endmodule

// File: tb/tb_tohost_reader.sv
// tb_tohost_reader: scoreboard bench for tohost_reader.
// Expected entries are queued at drive time and popped on host handshakes.
module tb_tohost_reader;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             csr_we;
  logic [31:0]      csr_wdata;
  logic             host_valid;
  logic             host_ready;
  logic [31:0]      host_data;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             done;
  logic             pass;
  logic [30:0]      fail_code;

  tohost_reader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .csr_we     (csr_we),
    .csr_wdata  (csr_wdata),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_data  (host_data),
    .count      (count),
    .overflow   (overflow),
    .done       (done),
    .pass       (pass),
    .fail_code  (fail_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [31:0] sb[$];
  logic        m_ovf;
  int          m_st;
  logic [30:0] m_code;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("count", 32'(count), 32'(sb.size()));
    check("valid", 32'(host_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) check("data", host_data, sb[0]);
    else                check("data0", host_data, 32'h0);
    check("ovf", 32'(overflow), 32'(m_ovf));
    check("done", 32'(done), 32'(m_st != 0));
    check("pass", 32'(pass), 32'(m_st == 1));
    check("fcode", 32'(fail_code), 32'(m_code));
  endtask

  // One clock: drive after negedge, check, model the rising edge.
  task automatic step(input logic we, input logic [31:0] d,
                      input logic rdy);
    logic do_pop;
    csr_we     = we;
    csr_wdata  = d;
    host_ready = rdy;
    #1;
    check_outputs();
    do_pop = (sb.size() != 0) && rdy;
    @(posedge clk);
    if (do_pop) void'(sb.pop_front());
    if (we) begin
      if (sb.size() < DEPTH) sb.push_back(d);
      else m_ovf = 1'b1;
      if (m_st == 0 && d[0]) begin
        if (d == 32'h1) m_st = 1;
        else begin
          m_st   = 2;
          m_code = d[31:1];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic model_clear();
    sb.delete();
    m_ovf  = 1'b0;
    m_st   = 0;
    m_code = '0;
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_cnt", 32'(count), 32'h0);
    check("rst_vld", 32'(host_valid), 32'h0);
    check("rst_dat", host_data, 32'h0);
    check("rst_done", 32'(done), 32'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1);
    check("drained", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    csr_we     = 1'b0;
    csr_wdata  = '0;
    host_ready = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Single PASS write, immediately consumed.
    step(1'b1, 32'h1, 1'b1);
    check("pass_v", 32'(host_valid), 32'h1);
    check("pass_d", host_data, 32'h1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Fill, overflow, ordered drain.
    do_reset();
    step(1'b1, 32'h5, 1'b0);
    step(1'b1, 32'h8, 1'b0);
    step(1'b1, 32'ha, 1'b0);
    step(1'b1, 32'hb, 1'b0);
    check("full4", 32'(count), 32'd4);
    step(1'b1, 32'hc, 1'b0);
    check("ovf1", 32'(overflow), 32'h1);
    drain(6);

    // Full with simultaneous pop: write accepted.
    do_reset();
    step(1'b1, 32'h10, 1'b0);
    step(1'b1, 32'h12, 1'b0);
    step(1'b1, 32'h14, 1'b0);
    step(1'b1, 32'h16, 1'b0);
    step(1'b1, 32'he, 1'b1);
    check("full_pop_cnt", 32'(count), 32'd4);
    check("full_pop_ovf", 32'(overflow), 32'h0);
    drain(6);

    // FAIL is terminal.
    do_reset();
    step(1'b1, 32'h0000000b, 1'b0);
    check("fail_code", 32'(fail_code), 32'd5);
    step(1'b1, 32'h1, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("still_fail", 32'(pass), 32'h0);
    drain(4);

    // Reset mid-stream discards queued entries.
    do_reset();
    step(1'b1, 32'h2, 1'b0);
    step(1'b1, 32'h4, 1'b0);
    check("run_done", 32'(done), 32'h0);
    do_reset();
    step(1'b1, 32'h1, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    drain(3);

    // Randomised traffic with even payloads plus rare status writes.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] v;
      v = $urandom() & 32'hffff_fffe;
      if ($urandom_range(0, 40) == 0) v[0] = 1'b1;
      step(1'($urandom_range(0, 2) != 0), v,
           1'($urandom_range(0, 1)));
      if (i == 150) do_reset();
    end
    drain(6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
